// File: rtl/ten_bit_adder.sv
// rtl/ten_bit_adder.sv - 10-bit registered ripple-carry add/subtract unit, MSB at bit 0.
// Optional TEN_BIT_ADDER_SAT_EN clamps overflowing adds to 1023 and underflowing subtracts to 0.
module ten_bit_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       op_sub,
  input  logic [0:9] a,
  input  logic [0:9] b,
  output logic [0:9] result,
  output logic       carry_out,
  output logic       out_valid
);

  // Returns {carry out of bit 0, sum[0:9]}; the chain starts at bit 9 (LSB).
  function automatic logic [0:10] ripple_chain(input logic [0:9] x, input logic [0:9] y,
                                               input logic cin);
    logic [0:10] r;
    logic        c;
    r = '0;
    c = cin;
    for (int i = 9; i >= 0; i--) begin
      r[i+1] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    r[0] = c;
    return r;
  endfunction

  logic [0:9]  b_eff;
  logic [0:10] chain;
  logic        flag_d;
  logic [0:9]  result_d;
  logic [0:9]  result_q;
  logic        carry_q;
  logic        valid_q;

  always_comb begin
    b_eff    = op_sub ? ~b : b;
    chain    = ripple_chain(a, b_eff, op_sub);
    // A subtract borrows exactly when the two's-complement chain produces no carry.
    flag_d   = op_sub ? ~chain[0] : chain[0];
    result_d = chain[1:10];
`ifdef TEN_BIT_ADDER_SAT_EN
    if (flag_d) begin
      result_d = op_sub ? 10'd0 : 10'd1023;
    end
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        carry_q  <= flag_d;
      end
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ten_bit_adder.sv
// tb/tb_ten_bit_adder.sv - directed self-checking bench for ten_bit_adder.
module tb_ten_bit_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       op_sub;
  logic [0:9] a;
  logic [0:9] b;
  logic [0:9] result;
  logic       carry_out;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

`ifdef TEN_BIT_ADDER_SAT_EN
  localparam int ADD_OVF_1000_100 = 1023;
  localparam int SUB_UNF_100_300  = 0;
  localparam int ADD_OVF_1023_1   = 1023;
  localparam int SUB_UNF_0_1      = 0;
`else
  localparam int ADD_OVF_1000_100 = 76;
  localparam int SUB_UNF_100_300  = 824;
  localparam int ADD_OVF_1023_1   = 0;
  localparam int SUB_UNF_0_1      = 1023;
`endif

  ten_bit_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .result    (result),
    .carry_out (carry_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One isolated operation: drive on a falling edge, check one cycle later, then check the pulse ends.
  task automatic single_op(input string tag, input logic s, input int av, input int bv,
                           input int er, input logic ec);
    @(negedge clk);
    op_sub = s; a = 10'(av); b = 10'(bv); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".result"}, 32'(result), 32'(er));
    check({tag, ".carry"},  32'(carry_out), 32'(ec));
    check({tag, ".valid"},  32'(out_valid), 32'd1);
    @(negedge clk);
    check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, ".result_kept"}, 32'(result), 32'(er));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; op_sub = 1'b0; a = 10'd7; b = 10'd9;
    @(negedge clk);
    @(negedge clk);
    check("reset.result", 32'(result), 32'd0);
    check("reset.carry",  32'(carry_out), 32'd0);
    check("reset.valid",  32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    single_op("add_200_100",   1'b0, 200,  100, 300, 1'b0);
    single_op("add_1000_100",  1'b0, 1000, 100, ADD_OVF_1000_100, 1'b1);
    single_op("sub_300_100",   1'b1, 300,  100, 200, 1'b0);
    single_op("sub_100_300",   1'b1, 100,  300, SUB_UNF_100_300, 1'b1);
    single_op("sub_5_5",       1'b1, 5,    5,   0,   1'b0);
    single_op("add_1023_1",    1'b0, 1023, 1,   ADD_OVF_1023_1, 1'b1);
    single_op("sub_0_1",       1'b1, 0,    1,   SUB_UNF_0_1, 1'b1);
    single_op("add_1023_0",    1'b0, 1023, 0,   1023, 1'b0);
    single_op("add_341_682",   1'b0, 341,  682, 1023, 1'b0);

    // Back-to-back stream of three operations.
    @(negedge clk);
    op_sub = 1'b0; a = 10'd1; b = 10'd1; in_valid = 1'b1;
    @(negedge clk);
    check("b2b0.result", 32'(result), 32'd2);
    check("b2b0.valid",  32'(out_valid), 32'd1);
    op_sub = 1'b0; a = 10'd1023; b = 10'd0;
    @(negedge clk);
    check("b2b1.result", 32'(result), 32'd1023);
    check("b2b1.carry",  32'(carry_out), 32'd0);
    check("b2b1.valid",  32'(out_valid), 32'd1);
    op_sub = 1'b1; a = 10'd5; b = 10'd5;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b2.result", 32'(result), 32'd0);
    check("b2b2.valid",  32'(out_valid), 32'd1);
    @(negedge clk);
    check("b2b.valid_drop", 32'(out_valid), 32'd0);

    // Hold: operands change while in_valid stays low.
    single_op("hold_seed", 1'b0, 1000, 100, ADD_OVF_1000_100, 1'b1);
    a = 10'd3; b = 10'd4; op_sub = 1'b1;
    @(negedge clk);
    a = 10'd512; b = 10'd600;
    @(negedge clk);
    check("hold.result", 32'(result), 32'(ADD_OVF_1000_100));
    check("hold.carry",  32'(carry_out), 32'd1);
    check("hold.valid",  32'(out_valid), 32'd0);

    // Asynchronous reset while a result is being presented.
    @(negedge clk);
    op_sub = 1'b0; a = 10'd1000; b = 10'd100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("midrst.pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.result", 32'(result), 32'd0);
    check("midrst.carry",  32'(carry_out), 32'd0);
    check("midrst.valid",  32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst.post_valid",  32'(out_valid), 32'd0);
    check("midrst.post_result", 32'(result), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ten_bit_adder.md
TEN_BIT_ADDER -- requirements
Module: ten_bit_adder

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 10 bits, and all vectors SHALL be declared [0:9] with bit 0 as MSB.
REQ-002 clk  input  1  single clock; all state SHALL be on its rising edge.
REQ-003 rst_n  input  1  reset, SHALL be asynchronous and active-low.
REQ-004 in_valid  input  1  operands and op_sub SHALL be sampled on the clk edge where in_valid=1.
REQ-005 op_sub  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-006 a  input  10  unsigned operand A (balance).
REQ-007 b  input  10  unsigned operand B (balance or amount).
REQ-008 result  output  10  registered unsigned result.
REQ-009 carry_out  output  1  add: sum exceeded 1023; sub: borrow, i.e. b>a.
REQ-010 out_valid  output  1  high for exactly one cycle when result/carry_out hold a new value.

Function
REQ-011 Core SHALL be a 10-stage ripple-carry chain of full adders, with an LSB (bit 9) carry-in of 0 for add and 1 for subtract, and b inverted for subtract.
REQ-012 Latency SHALL be 1 cycle: operands sampled at edge N SHALL appear on result/carry_out with out_valid=1 after edge N.
REQ-013 out_valid SHALL fall on the next edge unless in_valid is again 1; back-to-back inputs SHALL yield a result every cycle.
REQ-014 When in_valid=0, result and carry_out SHALL hold their last values.
REQ-015 Add without saturation: result SHALL equal (a+b) mod 1024, and carry_out SHALL equal 1 if and only if a+b>1023.
REQ-016 Subtract without saturation: result SHALL equal (a-b) mod 1024, and carry_out SHALL equal 1 if and only if b>a; a==b SHALL give 0 with carry_out=0.
REQ-017 Outputs SHALL be glitch-free registers; no combinational path SHALL exist from inputs to outputs.

Reset
REQ-018 rst_n=0 SHALL immediately force result=0, carry_out=0, out_valid=0, independent of clk.
REQ-019 An operation sampled in the same cycle that reset asserts SHALL be discarded; the first sample SHALL occur on the first rising edge with rst_n=1.

Configuration
REQ-020 Macro TEN_BIT_ADDER_SAT_EN, when defined, SHALL make an add with carry_out=1 produce result=1023 and a subtract with carry_out=1 produce result=0, with carry_out still reported.
REQ-021 Without TEN_BIT_ADDER_SAT_EN, results SHALL wrap modulo 1024 per REQ-015/016; the flag and latency behaviour SHALL be identical in both builds.

Verification
REQ-022 Add, a=200, b=100, in_valid pulse -> after 1 edge, result=300, carry_out=0, out_valid=1 for one cycle.
REQ-023 Add, a=1000, b=100 -> carry_out=1; result=76 without the macro, 1023 with TEN_BIT_ADDER_SAT_EN.
REQ-024 Subtract, a=300, b=100 -> result=200, carry_out=0; a=100, b=300 -> carry_out=1, result=824 (no macro) or 0 (macro).
REQ-025 Back-to-back: three consecutive in_valid cycles (1+1, 1023+0, 5-5) -> results 2, 1023, 0 on consecutive cycles, with out_valid held high for 3 cycles.
REQ-026 Reset mid-operation: assert rst_n=0 between clk edges while out_valid=1 -> outputs become 0 at once; after release with in_valid=0, out_valid stays 0.
REQ-027 Hold: after a valid op, keep in_valid=0 and toggle a/b -> result and carry_out remain unchanged.
